// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
// Used by mem_arbiter and rr_picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        RD,
        WR
    } req_kind_t;

    localparam int unsigned MEM_ARB_N_REQ_DEF   = 2;
    localparam int unsigned MEM_ARB_ADDR_W_DEF  = 32;
    localparam int unsigned MEM_ARB_DATA_W_DEF  = 64;
    localparam int unsigned MEM_ARB_TIMEOUT_DEF = 1024;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first active requester
// at or after ptr_i, wrapping at N_REQ.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ = MEM_ARB_N_REQ_DEF,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] active_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = IDX_W'((32'(ptr_i) + off) % N_REQ);
            if (!any_o && active_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port among N_REQ cache requesters.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = MEM_ARB_N_REQ_DEF,
    parameter int unsigned ADDR_W         = MEM_ARB_ADDR_W_DEF,
    parameter int unsigned DATA_W         = MEM_ARB_DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_rd_en,
    input  logic [N_REQ-1:0]         req_wd_en,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wd_data,
    output logic [DATA_W-1:0]        req_rd_data,
    output logic [N_REQ-1:0]         req_data_valid,
    output logic [N_REQ-1:0]         req_wd_valid,
    output logic [N_REQ-1:0]         req_err,
    output logic [N_REQ-1:0]         grant,
    output logic                     mem_rd_en,
    output logic                     mem_wd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wd_data,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_data_valid,
    input  logic                     mem_wd_valid
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    state_t            state_q, state_d;
    req_kind_t         kind_q, kind_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              rd_done;
    logic              wr_done;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .active_i (req_rd_en | req_wd_en),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Held at zero outside BUSY, so it is already clear on entry.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == BUSY) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = (state_q == BUSY) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign req_err = (state_q == DONE && err_q) ? grant_q : '0;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign req_err            = '0;
`endif

    assign rd_done = (kind_q == RD) && mem_data_valid;
    assign wr_done = (kind_q == WR) && mem_wd_valid;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    grant_d = pick_gnt;
                    idx_d   = pick_idx;
                    // Both enables high is illegal; the read wins.
                    kind_d  = req_rd_en[pick_idx] ? RD : WR;
                    addr_d  = req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
                    wdata_d = req_wd_data[32'(pick_idx) * DATA_W +: DATA_W];
                    err_d   = 1'b0;
                end
            end
            BUSY: begin
                if (rd_done) begin
                    rdata_d = mem_data;
                    state_d = DONE;
                end else if (wr_done) begin
                    state_d = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= RD;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign grant          = grant_q;
    assign mem_rd_en      = (state_q == BUSY) && (kind_q == RD);
    assign mem_wd_en      = (state_q == BUSY) && (kind_q == WR);
    assign mem_addr       = addr_q;
    assign mem_wd_data    = wdata_q;
    assign req_rd_data    = rdata_q;
    assign req_data_valid = (state_q == DONE && kind_q == RD && !err_q) ? grant_q : '0;
    assign req_wd_valid   = (state_q == DONE && kind_q == WR && !err_q) ? grant_q : '0;

endmodule
